// File: rtl/nbit_chunked_subtractor.sv
// Multi-cycle unsigned subtractor: CHUNK_BITS per cycle with a registered borrow, D = {borrow, difference}.
// Optional build macro NBIT_SUB_SATURATE_EN clamps the difference to zero on underflow.
module nbit_chunked_subtractor #(
   parameter int BIT_NUMBER = 8,
   parameter int CHUNK_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIT_NUMBER-1:0] num_one,
   input  logic [BIT_NUMBER-1:0] num_two,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIT_NUMBER:0]   D,
   output logic                  busy
);

   localparam int N_CHUNKS = BIT_NUMBER / CHUNK_BITS;
   localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [BIT_NUMBER-1:0] minuend_q, minuend_d;
   logic [BIT_NUMBER-1:0] subtrahend_q, subtrahend_d;
   logic                  borrow_q, borrow_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_NUMBER:0]   d_q, d_d;

   logic [CHUNK_BITS:0]   chunkSub;
   logic [BIT_NUMBER-1:0] rotated;
   logic [BIT_NUMBER-1:0] finalDiff;

   // The minuend register doubles as the difference register: each RUN cycle the
   // low chunk is consumed and its difference chunk enters at the top, so after
   // N_CHUNKS cycles the register holds the full difference in place.
   always_comb begin
      chunkSub = {1'b0, minuend_q[CHUNK_BITS-1:0]}
               - {1'b0, subtrahend_q[CHUNK_BITS-1:0]}
               - {{CHUNK_BITS{1'b0}}, borrow_q};
      rotated  = (minuend_q >> CHUNK_BITS)
               | (BIT_NUMBER'(chunkSub[CHUNK_BITS-1:0]) << (BIT_NUMBER - CHUNK_BITS));
`ifdef NBIT_SUB_SATURATE_EN
      finalDiff = chunkSub[CHUNK_BITS] ? '0 : rotated;
`else
      finalDiff = rotated;
`endif
   end

   // Next-state logic: latch on accept, step one chunk per RUN cycle, hold in DONE.
   always_comb begin
      state_d      = state_q;
      minuend_d    = minuend_q;
      subtrahend_d = subtrahend_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      d_d          = d_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               minuend_d    = num_one;
               subtrahend_d = num_two;
               borrow_d     = 1'b0;
               cnt_d        = '0;
               state_d      = RUN;
            end
         end
         RUN: begin
            minuend_d    = rotated;
            subtrahend_d = subtrahend_q >> CHUNK_BITS;
            borrow_d     = chunkSub[CHUNK_BITS];
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CHUNK) begin
               d_d     = {chunkSub[CHUNK_BITS], finalDiff};
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         minuend_q    <= '0;
         subtrahend_q <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         d_q          <= '0;
      end else begin
         state_q      <= state_d;
         minuend_q    <= minuend_d;
         subtrahend_q <= subtrahend_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         d_q          <= d_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign D         = d_q;

endmodule

// File: tb/tb_nbit_chunked_subtractor.sv
// Self-checking bench for nbit_chunked_subtractor (BIT_NUMBER=8, CHUNK_BITS=4): vector table,
// multi-cycle corner sequences and a randomised run against an arithmetic reference model.
module tb_nbit_chunked_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] num_one;
   logic [7:0] num_two;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] D;
   logic       busy;

   int errors = 0;
   int checks = 0;

`ifdef NBIT_SUB_SATURATE_EN
   localparam logic [8:0] EXP_00_01 = 9'h100;
   localparam logic [8:0] EXP_7F_FF = 9'h100;
`else
   localparam logic [8:0] EXP_00_01 = 9'h1FF;
   localparam logic [8:0] EXP_7F_FF = 9'h180;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] exp;
      string      name;
   } vec_t;

   vec_t       vecs[8];
   logic [8:0] expQ[$];

   nbit_chunked_subtractor #(.BIT_NUMBER(8), .CHUNK_BITS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .num_one(num_one), .num_two(num_two), .out_valid(out_valid),
      .out_ready(out_ready), .D(D), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: plain signed arithmetic, then wrap or clamp.
   function automatic logic [8:0] refD(input logic [7:0] a, input logic [7:0] b);
      int diff;
      int wrapped;
      diff    = int'(a) - int'(b);
      wrapped = (diff + 256) % 256;
`ifdef NBIT_SUB_SATURATE_EN
      if (diff < 0) wrapped = 0;
`endif
      return {(diff < 0), wrapped[7:0]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present operands and hold until accepted; returns just after the accept edge.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      int n;
      in_valid = 1'b1;
      num_one  = a;
      num_two  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) checkOutput("accept timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic runTxn(input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input string name);
      int lat;
      applyStimulus(a, b);
      checkOutput({name, " busy"}, {30'd0, busy, in_ready}, 32'b10);
      waitResult(lat);
      checkOutput({name, " latency"}, 32'(lat), 32'd2);
      checkOutput({name, " D"}, 32'(D), 32'(exp));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({name, " idle"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int received;
      int cyc;

      vecs[0] = '{8'h5A, 8'h23, 9'h037, "basic"};
      vecs[1] = '{8'h10, 8'h01, 9'h00F, "chunk borrow"};
      vecs[2] = '{8'h00, 8'h00, 9'h000, "zero"};
      vecs[3] = '{8'h00, 8'h01, EXP_00_01, "underflow 00-01"};
      vecs[4] = '{8'h7F, 8'hFF, EXP_7F_FF, "underflow 7F-FF"};
      vecs[5] = '{8'hFF, 8'h00, 9'h0FF, "max minus zero"};
      vecs[6] = '{8'hFF, 8'hFF, 9'h000, "equal max"};
      vecs[7] = '{8'h80, 8'h7F, 9'h001, "cross half"};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num_one = '0; num_two = '0;
      #2;
      checkOutput("reset state", {21'd0, in_ready, out_valid, busy, D}, {21'd0, 3'b100, 9'h000});
      tick();
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         runTxn(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      end

      // Backpressure: new operands offered while DONE must wait for the handshake.
      applyStimulus(8'h20, 8'h05);
      waitResult(lat);
      checkOutput("bp latency", 32'(lat), 32'd2);
      in_valid = 1'b1; num_one = 8'h44; num_two = 8'h11;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp hold", {21'd0, out_valid, in_ready, D}, {21'd0, 2'b10, 9'h01B});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bp handshake", {29'd0, out_valid, in_ready, busy}, 32'b010);
      tick();
      in_valid = 1'b0;
      waitResult(lat);
      checkOutput("bp second latency", 32'(lat), 32'd2);
      checkOutput("bp second D", 32'(D), 32'h033);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset one cycle after accept discards the operation.
      applyStimulus(8'h5A, 8'h23);
      rst = 1'b1;
      #1;
      checkOutput("mid reset", {20'd0, in_ready, out_valid, busy, D}, {20'd0, 3'b100, 9'h000});
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("post reset quiet", {30'd0, out_valid, in_ready}, 32'b01);
      end
      runTxn(8'h33, 8'h11, 9'h022, "after reset");

      // Randomised producer/consumer with an in-order scoreboard.
      received = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [7:0] a;
               logic [7:0] b;
               int n;
               a = 8'($urandom);
               b = 8'($urandom);
               while ($urandom_range(0, 3) == 0) tick();
               in_valid = 1'b1; num_one = a; num_two = b;
               n = 0;
               while (!in_ready && n < 200) begin
                  tick();
                  n++;
               end
               if (n >= 200) begin
                  checkOutput("rand accept timeout", 32'(in_ready), 32'd1);
                  break;
               end
               expQ.push_back(refD(a, b));
               tick();
               in_valid = 1'b0;
            end
         end
         begin
            cyc = 0;
            while (received < 1000 && cyc < 60000) begin
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  if (expQ.size() == 0) begin
                     checkOutput("rand unexpected result", 32'(D), 32'h1_0000);
                  end else begin
                     checkOutput("rand D", 32'(D), 32'(expQ.pop_front()));
                  end
                  received++;
               end
               tick();
               cyc++;
            end
            out_ready = 1'b0;
         end
      join
      checkOutput("rand received count", 32'(received), 32'd1000);
      checkOutput("rand leftover", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nbit_chunked_subtractor.md
# nbit_chunked_subtractor

Multi-cycle unsigned subtractor, the inverse of the n-bit CLA adder: computes num_one − num_two and reports the borrow, processing CHUNK_BITS bits per cycle with a registered borrow between chunks. Trades latency for a short combinational path. Sits in the arithmetic datapath next to the adders, with valid/ready handshakes on both sides. The result format mirrors the adder's S output: {borrow, difference}.

## Interface
- BIT_NUMBER, 8: operand width; must be a multiple of CHUNK_BITS.
- CHUNK_BITS, 4: bits subtracted per cycle; N_CHUNKS = BIT_NUMBER/CHUNK_BITS, N_CHUNKS ≥ 1.

- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- num_one  input  BIT_NUMBER  minuend; sampled on accept.
- num_two  input  BIT_NUMBER  subtrahend; sampled on accept.
- out_valid  output  1  D valid.
- out_ready  input  1  consumer accepts D.
- D  output  BIT_NUMBER+1  {borrow, difference}; borrow = 1 iff num_one < num_two.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch both operands, clear borrow register and chunk counter, go to RUN.
- RUN: each cycle subtract chunk k (bits k·CHUNK_BITS upward) with the registered borrow-in, store difference chunk, register borrow-out, increment counter. After chunk N_CHUNKS−1 → DONE.
- DONE: out_valid=1, D = {final borrow, difference}. On out_ready → IDLE.
- Difference is num_one − num_two modulo 2^BIT_NUMBER (two's-complement wrap) unless saturation is compiled in.
- Inputs change while not in IDLE: ignored; operands come only from the latched copies.
- in_valid in non-IDLE states: not accepted; producer must hold until in_ready.
- out_ready while not in DONE: no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, D=0, borrow register 0, counter 0.
- Accept at edge t (in_valid & in_ready). RUN occupies cycles t+1..t+N_CHUNKS; out_valid rises after edge t+N_CHUNKS. Latency N_CHUNKS cycles.
- D and out_valid stay stable while out_valid=1 and out_ready=0.
- Output handshake at edge u → IDLE; in_ready=1 from cycle u+1. No accept in the same cycle as output handshake. Maximum throughput is one result per N_CHUNKS+2 cycles.
- D holds its last value in IDLE. It is updated only when the DONE state is entered.
- rst asserted at any time, including mid-RUN or in DONE: immediate return to reset values. The partial result is discarded and no out_valid is produced.
- N_CHUNKS=1: single RUN cycle, latency 1.

## Configuration
- NBIT_SUB_SATURATE_EN defined: when the final borrow is 1, the difference field of D is forced to 0. D[BIT_NUMBER] still reads 1. Example: 0x00−0x01 → D=9'h100.
- NBIT_SUB_SATURATE_EN undefined: wrap-around. Example: 0x00−0x01 → D=9'h1FF.
- Latency, handshake and state behaviour are identical in both builds.

## Test plan
All scenarios use BIT_NUMBER=8 and CHUNK_BITS=4.
- Basic: 0x5A − 0x23 → D=9'h037 exactly 2 cycles after accept; out_ready=1 → IDLE.
- Inter-chunk borrow: 0x10 − 0x01 → D=9'h00F. 0x00 − 0x00 → D=9'h000.
- Underflow: 0x00 − 0x01 → D=9'h1FF (9'h100 with NBIT_SUB_SATURATE_EN). 0x7F − 0xFF → D=9'h180 (9'h100 saturated).
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven. Required: D stable, in_ready=0, new operands not accepted. They are accepted only after the output handshake.
- Reset mid-operation: assert rst the cycle after accept. Required: out_valid=0, in_ready=1, D=0 immediately. The next 0x33 − 0x11 yields 9'h022.
- Randomised back-to-back: 1000 operand pairs with random in_valid/out_ready. Every D equals {num_one<num_two, (num_one−num_two) mod 256}, in order with no drops or duplicates.
